// File: rtl/wb_commit_pkg.sv
// Shared definitions for the writeback/commit stage: exception-word layout,
// ecode constants and the exception-control state encoding.
package wb_commit_pkg;

  localparam int unsigned EXP_W     = 7;
  localparam int unsigned EXP_VALID = 6;

  localparam logic [5:0] ECODE_INT = 6'h00;
  localparam logic [5:0] ECODE_ADE = 6'h08;
  localparam logic [5:0] ECODE_ALE = 6'h09;
  localparam logic [5:0] ECODE_SYS = 6'h0b;
  localparam logic [5:0] ECODE_BRK = 6'h0c;
  localparam logic [5:0] ECODE_INE = 6'h0d;

  typedef enum logic {
    WB_RUN   = 1'b0,
    WB_FLUSH = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_exc_ctrl.sv
// Exception control for the commit stage: RUN/FLUSH FSM, flush-length counter,
// captured era/ecode and the one-cycle redirect pulse toward fetch.
module wb_exc_ctrl
  import wb_commit_pkg::*;
#(
  parameter logic [31:0] EENTRY       = 32'h1c00_8000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        exc_i,
  input  logic [31:0] pc_i,
  input  logic [5:0]  ecode_i,
  output logic        flush_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  output logic [31:0] era_o,
  output logic [5:0]  ecode_o
);

  wb_state_e   state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        redir_q, redir_d;
  logic [31:0] rpc_q, rpc_d;
  logic [31:0] era_q, era_d;
  logic [5:0]  ecode_q, ecode_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= WB_RUN;
      cnt_q   <= '0;
      redir_q <= 1'b0;
      rpc_q   <= '0;
      era_q   <= '0;
      ecode_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      redir_q <= redir_d;
      rpc_q   <= rpc_d;
      era_q   <= era_d;
      ecode_q <= ecode_d;
    end
  end

  // Exceptions seen while flushing belong to squashed instructions and are dropped.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    redir_d = 1'b0;
    rpc_d   = rpc_q;
    era_d   = era_q;
    ecode_d = ecode_q;
    case (state_q)
      WB_RUN: begin
        if (exc_i) begin
          state_d = WB_FLUSH;
          cnt_d   = 32'(FLUSH_CYCLES - 1);
          redir_d = 1'b1;
          rpc_d   = EENTRY;
          era_d   = pc_i;
          ecode_d = ecode_i;
        end
      end
      WB_FLUSH: begin
        if (cnt_q == '0) state_d = WB_RUN;
        else             cnt_d   = cnt_q - 32'd1;
      end
      default: state_d = WB_RUN;
    endcase
  end

  assign flush_o          = (state_q == WB_FLUSH);
  assign redirect_valid_o = redir_q;
  assign redirect_pc_o    = rpc_q;
  assign era_o            = era_q;
  assign ecode_o          = ecode_q;

endmodule

// File: rtl/wb_commit.sv
// Writeback/commit stage: register-file write gating, retire counter, optional
// commit trace (enabled by defining WB_COMMIT_TRACE_EN).
module wb_commit
  import wb_commit_pkg::*;
#(
  parameter logic [31:0] EENTRY       = 32'h1c00_8000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en_in0,
  input  logic [4:0]       addr_in0,
  input  logic [31:0]      data_in0,
  input  logic [31:0]      pc_in0,
  input  logic [EXP_W-1:0] exp_in,
  input  logic             en_in1,
  input  logic [4:0]       addr_in1,
  input  logic [31:0]      data_in1,
  input  logic [31:0]      pc_in1,
  output logic             rf_we0,
  output logic             rf_we1,
  output logic [4:0]       rf_waddr0,
  output logic [4:0]       rf_waddr1,
  output logic [31:0]      rf_wdata0,
  output logic [31:0]      rf_wdata1,
`ifdef WB_COMMIT_TRACE_EN
  output logic [1:0]       trace_valid,
  output logic [31:0]      trace_pc0,
  output logic [31:0]      trace_pc1,
  output logic [1:0]       trace_wen,
  output logic [4:0]       trace_wdest0,
  output logic [4:0]       trace_wdest1,
  output logic [31:0]      trace_wdata0,
  output logic [31:0]      trace_wdata1,
`endif
  output logic             flush_by_writeback,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic [31:0]      era,
  output logic [5:0]       ecode,
  output logic [63:0]      retire_cnt
);

  logic        flush;
  logic        exc, commit0, commit1, we0_d, we1_d;
  logic        we0_q, we1_q;
  logic [4:0]  waddr0_q, waddr1_q;
  logic [31:0] wdata0_q, wdata1_q;
  logic [63:0] retire_q, retire_d;

  wb_exc_ctrl #(
    .EENTRY       (EENTRY),
    .FLUSH_CYCLES (FLUSH_CYCLES)
  ) u_exc_ctrl (
    .clk              (clk),
    .rstn             (rstn),
    .exc_i            (exc),
    .pc_i             (pc_in0),
    .ecode_i          (exp_in[EXP_VALID-1:0]),
    .flush_o          (flush),
    .redirect_valid_o (redirect_valid),
    .redirect_pc_o    (redirect_pc),
    .era_o            (era),
    .ecode_o          (ecode)
  );

  // An excepting lane0 squashes lane1 as well; lane1 wins a same-rd collision.
  always_comb begin
    exc      = en_in0 & exp_in[EXP_VALID];
    commit0  = ~flush & en_in0 & ~exp_in[EXP_VALID];
    commit1  = ~flush & en_in1 & ~exc;
    we1_d    = commit1 & (addr_in1 != '0);
    we0_d    = commit0 & (addr_in0 != '0) & ~(we1_d & (addr_in1 == addr_in0));
    retire_d = retire_q + 64'(commit0) + 64'(commit1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      we0_q    <= 1'b0;
      we1_q    <= 1'b0;
      waddr0_q <= '0;
      waddr1_q <= '0;
      wdata0_q <= '0;
      wdata1_q <= '0;
      retire_q <= '0;
    end else begin
      we0_q    <= we0_d;
      we1_q    <= we1_d;
      waddr0_q <= addr_in0;
      waddr1_q <= addr_in1;
      wdata0_q <= data_in0;
      wdata1_q <= data_in1;
      retire_q <= retire_d;
    end
  end

  assign rf_we0             = we0_q;
  assign rf_we1             = we1_q;
  assign rf_waddr0          = waddr0_q;
  assign rf_waddr1          = waddr1_q;
  assign rf_wdata0          = wdata0_q;
  assign rf_wdata1          = wdata1_q;
  assign flush_by_writeback = flush;
  assign retire_cnt         = retire_q;

`ifdef WB_COMMIT_TRACE_EN
  logic [1:0]  tvalid_q, twen_q;
  logic [31:0] tpc0_q, tpc1_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tvalid_q <= '0;
      twen_q   <= '0;
      tpc0_q   <= '0;
      tpc1_q   <= '0;
    end else begin
      tvalid_q <= {commit1, commit0};
      twen_q   <= {we1_d, we0_d};
      tpc0_q   <= pc_in0;
      tpc1_q   <= pc_in1;
    end
  end

  assign trace_valid  = tvalid_q;
  assign trace_wen    = twen_q;
  assign trace_pc0    = tpc0_q;
  assign trace_pc1    = tpc1_q;
  assign trace_wdest0 = waddr0_q;
  assign trace_wdest1 = waddr1_q;
  assign trace_wdata0 = wdata0_q;
  assign trace_wdata1 = wdata1_q;
`else
  logic unused_pc1;
  assign unused_pc1 = ^pc_in1;
`endif

endmodule
